riscv_regfile_sb: RTL and testbench

- Parametrised successor to the core's integer register file.
- Generalised in data width, register count, read-port count and write-port count.
- Adds a pending-write scoreboard for long-latency writebacks (e.g. load/mul-div) and a reset-time sweep FSM that zeroes storage one entry per cycle, so the array stays RAM-friendly.
- Sits in ID: read ports feed the operand muxes, write ports come from WB and the long-latency unit, and the issue port is driven by the decoder.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/riscv_rf_bypass.sv | 39 +++
 rtl/riscv_regfile_sb.sv | 150 +++++++++++++++
 tb/tb_riscv_regfile_sb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the integer register file with scoreboard.
//
// Contents:
//   XLEN_DEFAULT - default data width of the register file
//   REG_ZERO     - index of the hardwired zero register (x0)
//   rf_state_e   - states of the reset-time sweep FSM (INIT sweeps storage, RUN is normal operation)
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ZERO     = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

endpackage : riscv_pkg

// File: rtl/riscv_rf_bypass.sv
// Per-read-port write-bypass mux.
//
// Looks across all write ports for one that writes the register this read port addresses.
// It reports whether such a port exists and returns that port's data. When several ports
// match, the highest-index port wins, which is the same priority the storage write uses.
//
// Ports:
//   raddr - address presented on this read port
//   we    - write enables, one per write port
//   waddr - packed write addresses, port j at [j*AW +: AW]
//   wdata - packed write data, port j at [j*XLEN +: XLEN]
//   hit   - some enabled write port targets raddr
//   data  - write data of the highest-index matching port (zero when there is no hit)
module riscv_rf_bypass #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NW   = 2
) (
  input  logic [AW-1:0]      raddr,
  input  logic [NW-1:0]      we,
  input  logic [NW*AW-1:0]   waddr,
  input  logic [NW*XLEN-1:0] wdata,
  output logic               hit,
  output logic [XLEN-1:0]    data
);

  // Scan the ports in ascending order so a later (higher-index) match overwrites an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < NW; j++) begin
      if (we[j] && (waddr[j*AW +: AW] == raddr)) begin
        hit  = 1'b1;
        data = wdata[j*XLEN +: XLEN];
      end
    end
  end

endmodule : riscv_rf_bypass

// File: rtl/riscv_regfile_sb.sv
// Parametrised integer register file with a pending-write scoreboard.
//
// After reset, an INIT sweep zeroes one storage entry per cycle, so the array never needs a
// parallel reset and stays RAM-friendly. ready rises once the sweep is complete. In RUN,
// the write ports update storage, and a same-cycle write is forwarded to the read ports.
// The issue port marks a destination as awaiting a long-latency writeback. Register x0 is
// hardwired: it always reads zero, is never pending, and writes or issues to it are dropped.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   ready     - high once the init sweep has completed
//   raddr     - NR packed read addresses, port i at [i*AW +: AW]
//   rdata     - NR packed read data, combinational, with bypass of same-cycle writes
//   rpend     - per read port: the addressed register still awaits a writeback
//   we/waddr/wdata - NW write ports; the higher index wins when ports collide
//   iss_valid/iss_rd - mark iss_rd as pending on the next edge
module riscv_regfile_sb
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NR    = 2,
  parameter int NW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic [NR*AW-1:0]   raddr,
  output logic [NR*XLEN-1:0] rdata,
  output logic [NR-1:0]      rpend,
  input  logic [NW-1:0]      we,
  input  logic [NW*AW-1:0]   waddr,
  input  logic [NW*XLEN-1:0] wdata,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd
);

  rf_state_e         state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  pend_q, pend_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   rf_q [NREGS];
  logic [XLEN-1:0]   rf_d [NREGS];

  logic              byp_hit  [NR];
  logic [XLEN-1:0]   byp_data [NR];

  // Next-state logic for the sweep FSM and the scoreboard. During INIT, the write and issue
  // ports are deliberately ignored. In RUN, write clears are applied before issue sets,
  // so an issue that collides with a writeback to the same register leaves the register
  // pending. The issuing instruction is younger and still owes a result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(NREGS - 1)) begin
        state_d = ST_RUN;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && (waddr[j*AW +: AW] != AW'(REG_ZERO))) begin
          pend_d[waddr[j*AW +: AW]] = 1'b0;
        end
      end
      if (iss_valid && (iss_rd != AW'(REG_ZERO))) begin
        pend_d[iss_rd] = 1'b1;
      end
    end
    pend_d[REG_ZERO] = 1'b0;
    ready_d = (state_d == ST_RUN);
  end

  // Storage update. INIT zeroes the entry at the sweep counter. RUN applies the write ports
  // in ascending order, so the highest-index port wins when two ports share an address.
  always_comb begin
    rf_d = rf_q;
    if (state_q == ST_INIT) begin
      rf_d[cnt_q] = '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && (waddr[j*AW +: AW] != AW'(REG_ZERO))) begin
          rf_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Control and scoreboard registers. Reset returns to INIT and clears every pending bit
  // at once; ready is registered so it comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      pend_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  // The storage array has no reset of its own. The INIT sweep clears it after every reset.
  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  assign ready = ready_q;

  // One bypass mux per read port.
  for (genvar i = 0; i < NR; i++) begin : g_rport
    riscv_rf_bypass #(
      .XLEN (XLEN),
      .AW   (AW),
      .NW   (NW)
    ) u_bypass (
      .raddr (raddr[i*AW +: AW]),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .hit   (byp_hit[i]),
      .data  (byp_data[i])
    );
  end

  // Read ports. Everything reads zero and not-pending until the sweep is done. A same-cycle
  // write takes precedence over storage and also masks the pending bit, because the data
  // is arriving now. A same-cycle issue is not forwarded, so rpend shows pre-edge state.
  always_comb begin
    rdata = '0;
    rpend = '0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NR; i++) begin
        if (raddr[i*AW +: AW] != AW'(REG_ZERO)) begin
          if (byp_hit[i]) begin
            rdata[i*XLEN +: XLEN] = byp_data[i];
          end else begin
            rdata[i*XLEN +: XLEN] = rf_q[raddr[i*AW +: AW]];
            rpend[i]              = pend_q[raddr[i*AW +: AW]];
          end
        end
      end
    end
  end

endmodule : riscv_regfile_sb

// File: tb/tb_riscv_regfile_sb.sv
// Directed testbench for riscv_regfile_sb with the default parameters
// (XLEN=32, NREGS=32, NR=2, NW=2).
module tb_riscv_regfile_sb;

  logic        clk;
  logic        rst;
  logic        ready;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rpend;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;

  int testCount = 0;
  int failCount = 0;

  riscv_regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .raddr     (raddr),
    .rdata     (rdata),
    .rpend     (rpend),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge and settle, so checks happen away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every DUT input for the current cycle, then let the combinational outputs settle.
  task automatic applyStimulus(input logic [1:0] weV,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic issV, input logic [4:0] issRd);
    we        = weV;
    waddr     = {wa1, wa0};
    wdata     = {wd1, wd0};
    raddr     = {ra1, ra0};
    iss_valid = issV;
    iss_rd    = issRd;
    #1;
  endtask

  // Compare one observed value against its expected value and count the comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Hold reset for one edge, then check ready through the 32-edge sweep.
  // The first edges of the sweep optionally carry a write to x5, which must be dropped.
  task automatic resetAndSweep(input logic writeDuringInit);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      if (writeDuringInit && k <= 4)
        applyStimulus(2'b01, 5'd5, 32'hAAAA_5555, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 5'd5);
      else
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
      checkOutput("init_ready_low", 32'(ready), 32'd0);
      checkOutput("init_rdata0_zero", rdata[31:0], 32'd0);
      checkOutput("init_rpend0_zero", 32'(rpend[0]), 32'd0);
      tick();
    end
    checkOutput("ready_low_edge31", 32'(ready), 32'd0);
    tick();
    checkOutput("ready_high_edge32", 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);

    // Init sweep. A write and an issue to x5 during INIT must both be ignored.
    resetAndSweep(1'b1);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    checkOutput("x5_dropped_in_init", rdata[31:0], 32'd0);
    checkOutput("x5_not_pending", 32'(rpend[0]), 32'd0);

    // Write x3 with a same-cycle bypass, then read it back from storage.
    applyStimulus(2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);
    checkOutput("bypass_x3_p0", rdata[31:0], 32'hDEAD_BEEF);
    checkOutput("bypass_x3_p1", rdata[63:32], 32'hDEAD_BEEF);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b0, 5'd0);
    checkOutput("stored_x3", rdata[31:0], 32'hDEAD_BEEF);
    checkOutput("x7_swept_zero", rdata[63:32], 32'd0);

    // Both write ports target x7. Port 1 wins in the bypass and in storage.
    applyStimulus(2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 5'd7, 5'd7, 1'b0, 5'd0);
    checkOutput("prio_bypass_p0", rdata[31:0], 32'h2);
    checkOutput("prio_bypass_p1", rdata[63:32], 32'h2);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd3, 1'b0, 5'd0);
    checkOutput("prio_stored_x7", rdata[31:0], 32'h2);
    checkOutput("x3_unchanged", rdata[63:32], 32'hDEAD_BEEF);

    // A write to x0 is dropped, and x0 always reads zero.
    applyStimulus(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
    checkOutput("x0_no_bypass", rdata[31:0], 32'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    checkOutput("x0_reads_zero", rdata[31:0], 32'd0);
    checkOutput("x0_not_pending", 32'(rpend[0]), 32'd0);

    // Issue x9. rpend shows pre-edge state in the issue cycle and is set afterwards.
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
    checkOutput("issue_no_bypass", 32'(rpend[0]), 32'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    checkOutput("x9_pending_p0", 32'(rpend[0]), 32'd1);
    checkOutput("x9_pending_p1", 32'(rpend[1]), 32'd1);
    // Writeback on port 1 masks pending and bypasses data in the same cycle.
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h55, 5'd9, 5'd9, 1'b0, 5'd0);
    checkOutput("wb_masks_pend", 32'(rpend[0]), 32'd0);
    checkOutput("wb_bypass_x9", rdata[31:0], 32'h55);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    checkOutput("x9_pend_cleared", 32'(rpend[0]), 32'd0);
    checkOutput("x9_stored", rdata[31:0], 32'h55);

    // Issue and write x4 on one edge. Data lands, and the register stays pending.
    applyStimulus(2'b01, 5'd4, 32'h77, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd0);
    checkOutput("collide_x4_data", rdata[31:0], 32'h77);
    checkOutput("collide_x4_pend", 32'(rpend[1]), 32'd1);

    // Set x10 = 0x123 and make x11 pending, then reset in the middle of RUN.
    applyStimulus(2'b01, 5'd10, 32'h123, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd11);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd11, 1'b0, 5'd0);
    checkOutput("pre_rst_x10", rdata[31:0], 32'h123);
    checkOutput("pre_rst_x11_pend", 32'(rpend[1]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'd11, 1'b0, 5'd0);
    checkOutput("rst_ready_low", 32'(ready), 32'd0);
    checkOutput("rst_x11_pend_low", 32'(rpend[1]), 32'd0);
    for (int k = 1; k <= 31; k++) tick();
    checkOutput("rerun_ready_low_edge31", 32'(ready), 32'd0);
    tick();
    checkOutput("rerun_ready_high", 32'(ready), 32'd1);
    checkOutput("x10_rezeroed", rdata[31:0], 32'd0);
    checkOutput("x11_pend_cleared", 32'(rpend[1]), 32'd0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd3, 1'b0, 5'd0);
    checkOutput("x4_rezeroed", rdata[31:0], 32'd0);
    checkOutput("x4_pend_cleared", 32'(rpend[0]), 32'd0);
    checkOutput("x3_rezeroed", rdata[63:32], 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule : tb_riscv_regfile_sb
